seg_scan_driver: RTL and testbench

Dynamic six-digit seven-segment scan driver that consumes the packed hour/minute/second word from the time counter and renders it as HH.MM.SS on a common-anode multiplexed display. It snapshots the time word once per frame to prevent tearing, converts each field to two decimal digits, and time-multiplexes the digit selects. A blanking interval before each digit slot suppresses ghosting. It is the last stage before the board pins.

---
 rtl/seg_pkg.sv | 30 +++
 rtl/seg_decode.sv | 27 ++
 rtl/seg_scan_driver.sv | 84 ++++++++
 tb/tb_seg_scan_driver.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment scan driver: digit count, active-low
// segment codes, time-word field positions and the decimal-point pattern.
package seg_pkg;

  localparam int DIGITS = 6;

  localparam logic [7:0] SEG_0 = 8'hC0;
  localparam logic [7:0] SEG_1 = 8'hF9;
  localparam logic [7:0] SEG_2 = 8'hA4;
  localparam logic [7:0] SEG_3 = 8'hB0;
  localparam logic [7:0] SEG_4 = 8'h99;
  localparam logic [7:0] SEG_5 = 8'h92;
  localparam logic [7:0] SEG_6 = 8'h82;
  localparam logic [7:0] SEG_7 = 8'hF8;
  localparam logic [7:0] SEG_8 = 8'h80;
  localparam logic [7:0] SEG_9 = 8'h90;
  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [5:0] SEL_OFF   = 6'h3F;

  localparam int HOUR_MSB = 16;
  localparam int HOUR_LSB = 12;
  localparam int MIN_MSB  = 11;
  localparam int MIN_LSB  = 6;
  localparam int SEC_MSB  = 5;
  localparam int SEC_LSB  = 0;

  // Digits 2 and 4 carry the separators of HH.MM.SS
  localparam logic [5:0] DP_MASK = 6'b010100;

endpackage

// File: rtl/seg_decode.sv
// BCD digit to active-low seven-segment code with the decimal point off;
// non-decimal inputs produce an all-dark pattern.
module seg_decode
  import seg_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [7:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (bcd)
      4'd0: seg = SEG_0;
      4'd1: seg = SEG_1;
      4'd2: seg = SEG_2;
      4'd3: seg = SEG_3;
      4'd4: seg = SEG_4;
      4'd5: seg = SEG_5;
      4'd6: seg = SEG_6;
      4'd7: seg = SEG_7;
      4'd8: seg = SEG_8;
      4'd9: seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg_scan_driver.sv
// Six-digit multiplexed HH.MM.SS display driver; the time word is captured
// once per frame so a frame never mixes old and new values.
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int TIME_SCAN = 50_000,
  parameter int BLANK     = 500
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [16:0] din,
  output logic [5:0]  sel,
  output logic [7:0]  seg
);

  localparam int CNT_W = $clog2(TIME_SCAN);

  logic [CNT_W-1:0] cnt;
  logic [2:0]       idx;
  logic [16:0]      snap;
  logic             end_cnt;
  logic             last_slot;
  logic             blank;
  logic [5:0]       field;
  logic [3:0]       ones;
  logic [3:0]       tens;
  logic [3:0]       digit;
  logic [7:0]       code;
  logic [7:0]       seg_next;
  logic [5:0]       sel_next;

  assign end_cnt   = (cnt == CNT_W'(TIME_SCAN - 1));
  assign last_slot = (idx == 3'(DIGITS - 1));

  if (BLANK > 0) begin : g_blank
    assign blank = (cnt < CNT_W'(BLANK));
  end else begin : g_no_blank
    assign blank = 1'b0;
  end

  // Pick the field for the current digit pair, then split it into decimal digits
  always_comb begin
    case (idx)
      3'd0, 3'd1: field = snap[SEC_MSB:SEC_LSB];
      3'd2, 3'd3: field = snap[MIN_MSB:MIN_LSB];
      default:    field = {1'b0, snap[HOUR_MSB:HOUR_LSB]};
    endcase
  end

  assign ones  = 4'(field % 6'd10);
  assign tens  = 4'(field / 6'd10);
  assign digit = idx[0] ? tens : ones;

  seg_decode u_decode (
    .bcd (digit),
    .seg (code)
  );

  assign seg_next = DP_MASK[idx] ? (code & 8'h7F) : code;
  assign sel_next = ~(6'b1 << idx);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      idx  <= '0;
      snap <= '0;
      sel  <= SEL_OFF;
      seg  <= SEG_BLANK;
    end else begin
      if (end_cnt) begin
        cnt <= '0;
        idx <= last_slot ? 3'd0 : idx + 3'd1;
        if (last_slot) begin
          snap <= din;
        end
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
      sel <= blank ? SEL_OFF   : sel_next;
      seg <= blank ? SEG_BLANK : seg_next;
    end
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Bench for seg_scan_driver: one instance with blanking, one without, both
// compared every cycle against a frame-level reference of the display.
module tb_seg_scan_driver;

  localparam int TS    = 10;
  localparam int BL    = 2;
  localparam int FRAME = 6 * TS;

  localparam logic [7:0] SEG_TAB [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                          8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [16:0] din = '0;
  logic [5:0]  sel, sel0;
  logic [7:0]  seg, seg0;

  int          checks = 0;
  int          passed = 0;
  int          pos = 0;
  logic [16:0] cur_val = '0;
  logic [13:0] exp_a = 14'h3FFF;
  logic [13:0] exp_b = 14'h3FFF;

  always #5 clk = ~clk;

  seg_scan_driver #(.TIME_SCAN(TS), .BLANK(BL)) dut (
    .clk(clk), .rst_n(rst_n), .din(din), .sel(sel), .seg(seg)
  );

  seg_scan_driver #(.TIME_SCAN(TS), .BLANK(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .din(din), .sel(sel0), .seg(seg0)
  );

  // Display contents at scan position p (cycles since reset) for frame value v
  function automatic logic [13:0] ref_out(int p, logic [16:0] v, int blank);
    int c, d, h, m, s;
    int digs [6];
    logic [5:0] rs;
    logic [7:0] rg;
    c = p % TS;
    d = (p / TS) % 6;
    h = int'(v[16:12]);
    m = int'(v[11:6]);
    s = int'(v[5:0]);
    digs[0] = s % 10; digs[1] = s / 10;
    digs[2] = m % 10; digs[3] = m / 10;
    digs[4] = h % 10; digs[5] = h / 10;
    if (c < blank) return {6'h3F, 8'hFF};
    rs = 6'h3F;
    rs[d] = 1'b0;
    rg = SEG_TAB[digs[d]];
    if (d == 2 || d == 4) rg[7] = 1'b0;
    return {rs, rg};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos = 0;
      cur_val = '0;
      exp_a = {6'h3F, 8'hFF};
      exp_b = {6'h3F, 8'hFF};
    end else begin
      exp_a = ref_out(pos, cur_val, BL);
      exp_b = ref_out(pos, cur_val, 0);
      if (pos % FRAME == FRAME - 1) cur_val = din;
      pos++;
    end
  end

  task automatic test_reset();
    logic [5:0] want_sel;
    din = '0;
    #1 rst_n = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if ({sel, seg} !== 14'h3FFF) $display("FAIL reset_hold got %h want 3fff", {sel, seg});
      else passed++;
      checks++;
      if ({sel0, seg0} !== 14'h3FFF) $display("FAIL reset_hold_nb got %h want 3fff", {sel0, seg0});
      else passed++;
    end
    rst_n = 1'b1;
    for (int i = 0; i < FRAME; i++) begin
      @(negedge clk);
      checks++;
      if ({sel, seg} !== exp_a) $display("FAIL first_frame pos=%0d got %h want %h", pos - 1, {sel, seg}, exp_a);
      else passed++;
      if ((pos - 1) % TS == TS - 1) begin
        want_sel = 6'h3F;
        want_sel[(pos - 1) / TS] = 1'b0;
        checks++;
        if ({sel, seg} !== {want_sel, ((((pos - 1) / TS) % 2) == 0 && (pos - 1) / TS != 0) ? 8'h40 : 8'hC0})
          $display("FAIL first_frame_zero slot=%0d got %h/%h", (pos - 1) / TS, sel, seg);
        else passed++;
      end
    end
  endtask

  // Load a time word and check the full frame that displays it
  task automatic test_pattern(input string name, input logic [16:0] val, input logic [47:0] want);
    int n, p, c, d, blanks, blanks0;
    logic [5:0] want_sel;
    din = val;
    n = 0;
    @(negedge clk);
    while (pos % FRAME != 0 && n < 2 * FRAME) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (pos % FRAME != 0) $display("FAIL %s_boundary_timeout got pos=%0d want frame start", name, pos);
    else passed++;
    blanks = 0;
    blanks0 = 0;
    for (int i = 0; i < FRAME; i++) begin
      @(negedge clk);
      p = pos - 1;
      c = p % TS;
      d = (p / TS) % 6;
      checks++;
      if ({sel, seg} !== exp_a) $display("FAIL %s_model pos=%0d got %h want %h", name, p, {sel, seg}, exp_a);
      else passed++;
      checks++;
      if ({sel0, seg0} !== exp_b) $display("FAIL %s_model_nb pos=%0d got %h want %h", name, p, {sel0, seg0}, exp_b);
      else passed++;
      if (sel === 6'h3F && seg === 8'hFF) blanks++;
      if (sel0 === 6'h3F && seg0 === 8'hFF) blanks0++;
      if (c == TS - 1) begin
        want_sel = 6'h3F;
        want_sel[d] = 1'b0;
        checks++;
        if ({sel, seg} !== {want_sel, want[8*d +: 8]})
          $display("FAIL %s_digit%0d got %h/%h want %h/%h", name, d, sel, seg, want_sel, want[8*d +: 8]);
        else passed++;
        checks++;
        if (blanks != BL || blanks0 != 0)
          $display("FAIL %s_blank%0d got %0d/%0d want %0d/0", name, d, blanks, blanks0, BL);
        else passed++;
        blanks = 0;
        blanks0 = 0;
      end
    end
  endtask

  // Starts at a frame boundary whose snapshot is 12:34:56
  task automatic test_snapshot();
    localparam logic [47:0] OLD = {8'hF9, 8'h24, 8'hB0, 8'h19, 8'h92, 8'h82};
    localparam logic [47:0] NEW = {8'hC0, 8'h79, 8'hC0, 8'h24, 8'hC0, 8'hB0};
    int p, c, d;
    logic [47:0] want;
    logic [5:0] want_sel;
    for (int i = 0; i < 2 * FRAME; i++) begin
      @(negedge clk);
      p = pos - 1;
      c = p % TS;
      d = (p / TS) % 6;
      want = (i < FRAME) ? OLD : NEW;
      checks++;
      if ({sel, seg} !== exp_a) $display("FAIL snap_model pos=%0d got %h want %h", p, {sel, seg}, exp_a);
      else passed++;
      if (c == TS - 1) begin
        want_sel = 6'h3F;
        want_sel[d] = 1'b0;
        checks++;
        if ({sel, seg} !== {want_sel, want[8*d +: 8]})
          $display("FAIL snap_digit%0d frame%0d got %h/%h want %h/%h", d, i / FRAME, sel, seg, want_sel, want[8*d +: 8]);
        else passed++;
      end
      if (i == 2 * TS + 5) din = {5'd1, 6'd2, 6'd3};
    end
  endtask

  task automatic test_async_reset();
    int n;
    n = 0;
    while (pos % FRAME != 3 * TS + 5 && n < 2 * FRAME) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (pos % FRAME != 3 * TS + 5) $display("FAIL async_align_timeout got pos=%0d", pos);
    else passed++;
    checks++;
    if (sel === 6'h3F) $display("FAIL async_pre_active got sel=%h want active digit", sel);
    else passed++;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({sel, seg} !== 14'h3FFF) $display("FAIL async_immediate got %h want 3fff", {sel, seg});
    else passed++;
    checks++;
    if ({sel0, seg0} !== 14'h3FFF) $display("FAIL async_immediate_nb got %h want 3fff", {sel0, seg0});
    else passed++;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < FRAME; i++) begin
      @(negedge clk);
      checks++;
      if ({sel, seg} !== exp_a) $display("FAIL async_restart pos=%0d got %h want %h", pos - 1, {sel, seg}, exp_a);
      else passed++;
      if (i == 0) begin
        checks++;
        if ({sel, seg} !== 14'h3FFF) $display("FAIL async_first_blank got %h want 3fff", {sel, seg});
        else passed++;
      end
      if (i == BL) begin
        checks++;
        if ({sel, seg} !== {6'h3E, 8'hC0}) $display("FAIL async_first_digit got %h/%h want 3e/c0", sel, seg);
        else passed++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_pattern("scan", {5'd12, 6'd34, 6'd56}, {8'hF9, 8'h24, 8'hB0, 8'h19, 8'h92, 8'h82});
    test_snapshot();
    test_pattern("range_2359", {5'd23, 6'd59, 6'd59}, {8'hA4, 8'h30, 8'h92, 8'h10, 8'h92, 8'h90});
    test_pattern("range_max", {5'd31, 6'd63, 6'd63}, {8'hB0, 8'h79, 8'h82, 8'h30, 8'h82, 8'hB0});
    din = {5'd9, 6'd8, 6'd7};
    test_async_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
